addr_decoder_n: RTL and testbench

Parametrised successor of the serial-address bus decoder. Receives a slave device address bit-serially from the master, validates it against NUM_SLAVES, gates the master valid to the selected slave and drives the read-mux select. Adds decode-error reporting, an explicit split-pending record, and an optional WAIT watchdog. Sits between the arbiter/master side and the slave muxes in the system bus.

---
 rtl/addr_decoder_n.sv | 180 ++++++++++++++++++
 tb/tb_addr_decoder_n.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/addr_decoder_n.sv
// Serial-address bus decoder: shifts in a slave address, gates master valid and drives the read-mux select.
// Optional WAIT watchdog is enabled by defining ADDR_DEC_TIMEOUT_EN.
module addr_decoder_n #(
    parameter int NUM_SLAVES        = 3,
    parameter int DEVICE_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES    = 255,
    localparam int SSEL_W           = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mwdata,
    input  logic                  mvalid,
    input  logic                  ssplit,
    input  logic                  split_grant,
    input  logic [NUM_SLAVES-1:0] sready,
    output logic [NUM_SLAVES-1:0] mvalid_s,
    output logic [SSEL_W-1:0]     ssel,
    output logic                  ack,
    output logic                  dec_err,
    output logic                  split_pending,
    output logic                  timeout
);

    localparam int AW    = DEVICE_ADDR_WIDTH;
    localparam int CNT_W = $clog2(DEVICE_ADDR_WIDTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ADDR    = 2'd1;
    localparam logic [1:0] ST_CONNECT = 2'd2;
    localparam logic [1:0] ST_WAIT    = 2'd3;

    logic [1:0]       state_r;
    logic [CNT_W-1:0] counter_r;
    logic [AW-1:0]    addr_r;
    logic [AW-1:0]    split_addr_r;
    logic [SSEL_W-1:0] ssel_r;
    logic             slave_en_r;
    logic             split_pending_r;
    logic             addr_hit_s;
    logic             addr_rdy_s;
    logic             addr_ok_s;
    logic             wait_expired_s;

    // Range check and ready lookup in one pass; only in-range indices ever touch sready.
    function automatic logic [1:0] slave_lookup(input logic [AW-1:0] a,
                                                input logic [NUM_SLAVES-1:0] rdy);
        logic hit;
        logic rd;
        hit = 1'b0;
        rd  = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit = hit | (a == AW'(i));
            rd  = rd  | ((a == AW'(i)) & rdy[i]);
        end
        return {hit, rd};
    endfunction

    // Address validation and combinational accept/error flags.
    always_comb begin
        {addr_hit_s, addr_rdy_s} = slave_lookup(addr_r, sready);
        addr_ok_s = addr_hit_s & addr_rdy_s;
        ack       = (state_r == ST_CONNECT) & addr_ok_s;
        dec_err   = (state_r == ST_CONNECT) & ~addr_ok_s;
    end

    // One-hot valid gating towards the selected slave.
    always_comb begin
        mvalid_s = {NUM_SLAVES{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            mvalid_s[i] = mvalid & slave_en_r & (ssel_r == SSEL_W'(i));
        end
    end

    // Main transfer FSM: serial capture, connect, wait, split bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            counter_r       <= {CNT_W{1'b0}};
            addr_r          <= {AW{1'b0}};
            split_addr_r    <= {AW{1'b0}};
            ssel_r          <= {SSEL_W{1'b0}};
            slave_en_r      <= 1'b0;
            split_pending_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    slave_en_r <= 1'b0;
                    if (mvalid) begin
                        addr_r[0] <= mwdata;
                        counter_r <= CNT_W'(1);
                        state_r   <= ST_ADDR;
                    end else if (split_grant && split_pending_r) begin
                        addr_r          <= split_addr_r;
                        split_pending_r <= 1'b0;
                        state_r         <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    addr_r[counter_r] <= mwdata;
                    if (counter_r == CNT_W'(DEVICE_ADDR_WIDTH - 1)) begin
                        counter_r <= {CNT_W{1'b0}};
                        state_r   <= ST_CONNECT;
                    end else begin
                        counter_r <= counter_r + CNT_W'(1);
                    end
                end
                ST_CONNECT: begin
                    slave_en_r <= 1'b1;
                    ssel_r     <= addr_r[SSEL_W-1:0];
                    if (!addr_ok_s) begin
                        state_r <= ST_IDLE;
                    end else if (mvalid) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_CONNECT;
                    end
                end
                ST_WAIT: begin
                    slave_en_r <= 1'b1;
                    ssel_r     <= addr_r[SSEL_W-1:0];
                    if (addr_rdy_s || ssplit) begin
                        state_r <= ST_IDLE;
                        // Only one split can be outstanding; a new one replaces the old record.
                        if (ssplit) begin
                            split_addr_r    <= addr_r;
                            split_pending_r <= 1'b1;
                        end else begin
                            split_pending_r <= split_pending_r;
                        end
                    end else if (wait_expired_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    slave_en_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADDR_DEC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_r;
    logic            timeout_r;

    assign wait_expired_s = (state_r == ST_WAIT) & (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1))
                          & ~(addr_rdy_s | ssplit);

    // Watchdog: counter is held at zero outside WAIT so every WAIT entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_r  <= {TO_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= wait_expired_s;
            if (state_r == ST_WAIT) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= {TO_W{1'b0}};
            end
        end
    end

    assign timeout = timeout_r;
`else
    // Watchdog compiled out: WAIT ends only on sready or ssplit; TIMEOUT_CYCLES stays referenced.
    assign wait_expired_s = 1'b0 & (TIMEOUT_CYCLES != 0);
    assign timeout        = 1'b0;
`endif

    assign ssel          = ssel_r;
    assign split_pending = split_pending_r;

endmodule

// File: tb/tb_addr_decoder_n.sv
// Directed bench for addr_decoder_n (NUM_SLAVES=3, W=4, TIMEOUT_CYCLES=8); expectations queued per step.
module tb_addr_decoder_n;

    logic       clk;
    logic       rst;
    logic       mwdata;
    logic       mvalid;
    logic       ssplit;
    logic       split_grant;
    logic [2:0] sready;
    logic [2:0] mvalid_s;
    logic [1:0] ssel;
    logic       ack;
    logic       dec_err;
    logic       split_pending;
    logic       timeout;

    typedef struct packed {
        logic [2:0] mvs;
        logic [1:0] sel;
        logic       ack;
        logic       err;
        logic       pend;
        logic       to;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    addr_decoder_n #(
        .NUM_SLAVES(3),
        .DEVICE_ADDR_WIDTH(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mwdata(mwdata),
        .mvalid(mvalid),
        .ssplit(ssplit),
        .split_grant(split_grant),
        .sready(sready),
        .mvalid_s(mvalid_s),
        .ssel(ssel),
        .ack(ack),
        .dec_err(dec_err),
        .split_pending(split_pending),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] mvs, input logic [1:0] s,
                                input logic a, input logic er, input logic p, input logic t);
        return {mvs, s, a, er, p, t};
    endfunction

    task automatic check_out();
        exp_t  e;
        exp_t  o;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard: observed empty queue, expected an entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = {mvalid_s, ssel, ack, dec_err, split_pending, timeout};
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: observed mvs=%b ssel=%0d ack=%b err=%b pend=%b to=%b, expected mvs=%b ssel=%0d ack=%b err=%b pend=%b to=%b",
                       t, o.mvs, o.sel, o.ack, o.err, o.pend, o.to,
                       e.mvs, e.sel, e.ack, e.err, e.pend, e.to);
            end
        end
    endtask

    // One bus cycle: drive inputs after the falling edge, queue what this cycle must show, compare.
    task automatic step(input string tag, input logic r, input logic m, input logic d,
                        input logic [2:0] sr, input logic sp, input logic sg, input exp_t e);
        @(negedge clk);
        rst = r; mvalid = m; mwdata = d; sready = sr; ssplit = sp; split_grant = sg;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1 check_out();
    endtask

    task automatic shift_addr(input string tag, input logic [3:0] a, input logic [1:0] s,
                              input logic p, input logic [2:0] first_mvs, input logic sg0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("%s_b%0d", tag, i), 1'b0, 1'b1, a[i], 3'b111, 1'b0,
                 (i == 0) ? sg0 : 1'b0,
                 mk((i == 0) ? first_mvs : 3'b000, s, 1'b0, 1'b0, p, 1'b0));
        end
    endtask

    initial begin
        rst = 1'b1; mvalid = 1'b0; mwdata = 1'b0; sready = 3'b111;
        ssplit = 1'b0; split_grant = 1'b0;
        repeat (2) @(posedge clk);
        step("reset", 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Address 2, good slave, one stalled WAIT cycle.
        shift_addr("a2", 4'd2, 2'd0, 1'b0, 3'b000, 1'b0);
        step("a2_connect", 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        step("a2_wait_stall", 1'b0, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0, mk(3'b100, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        step("a2_wait_done", 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b100, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        step("a2_idle", 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));

        // Address 5 is out of range.
        shift_addr("a5", 4'd5, 2'd2, 1'b0, 3'b000, 1'b0);
        step("a5_connect", 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0));
        step("a5_idle", 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Address 1 in range but slave 1 not ready.
        shift_addr("a1nr", 4'd1, 2'd1, 1'b0, 3'b000, 1'b0);
        step("a1nr_connect", 1'b0, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0, mk(3'b000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        step("a1nr_idle", 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Address 0 splits, then resumes on split_grant.
        shift_addr("sp0", 4'd0, 2'd1, 1'b0, 3'b000, 1'b0);
        step("sp0_connect", 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        step("sp0_wait_split", 1'b0, 1'b1, 1'b0, 3'b110, 1'b1, 1'b0, mk(3'b001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("sp0_idle_pend", 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        step("sp0_grant", 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b1, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        step("sp0_resume", 1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("sp0_resume_sel", 1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, mk(3'b001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("sp0_resume_done", 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("sp0_idle", 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Split on slave 1, then mvalid and split_grant collide: new address wins, pending kept.
        shift_addr("sp1", 4'd1, 2'd0, 1'b0, 3'b000, 1'b0);
        step("sp1_connect", 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        step("sp1_wait_split", 1'b0, 1'b1, 1'b0, 3'b101, 1'b1, 1'b0, mk(3'b010, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        shift_addr("col", 4'd2, 2'd1, 1'b1, 3'b010, 1'b1);
        step("col_connect_hold", 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0));
        step("col_connect_go", 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b100, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0));
        step("col_wait_rst", 1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0, mk(3'b100, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0));
        step("rst_wait_out", 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // split_grant with nothing pending is ignored; then reset mid-ADDR.
        step("grant_nopend", 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("ign_start", 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("ign_addr", 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("addr_rst", 1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Fresh transfer after reset must align again, then stall in WAIT.
        shift_addr("post", 4'd2, 2'd0, 1'b0, 3'b000, 1'b0);
        step("post_connect", 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++) begin
            step($sformatf("to_wait%0d", i), 1'b0, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0,
                 mk(3'b100, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        end
`ifdef ADDR_DEC_TIMEOUT_EN
        step("to_pulse", 1'b0, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0, mk(3'b100, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1));
        step("to_after", 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, mk(3'b000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
`else
        step("to_none", 1'b0, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0, mk(3'b100, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        step("to_release", 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b100, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        step("to_after", 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, mk(3'b000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
